// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;
  localparam logic [3:0]  FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side request/acknowledge bus shared by the arbiter and the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_be;
  logic              m_ack;
  logic [31:0]       m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_ack, m_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle counter; expired is high in the cycle the count reaches TIMEOUT-1.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // TIMEOUT of zero disables the watchdog entirely
  assign expired = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// data first with a streak limit so fetch is never starved.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              bus_err,
  mem_port_arbiter_if.master mbus
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [3:0]        m_be_q, m_be_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              bus_err_q, bus_err_d;

  logic              wd_clr, wd_en, wd_expired;
  logic              d_wins;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign wd_en  = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign d_wins = d_req && (!if_req || (streak_q < STREAK_W'(MAX_D_STREAK)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_I;
      streak_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_be_d     = m_be_q;
    if_valid_d = if_valid_q;
    d_valid_d  = d_valid_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    bus_err_d  = bus_err_q;
    wd_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d   = BUSY_D;
          owner_d   = OWNER_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
          wd_clr    = 1'b1;
          if (streak_q < STREAK_W'(MAX_D_STREAK)) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (if_req) begin
          state_d   = BUSY_I;
          owner_d   = OWNER_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          m_be_d    = FETCH_BE;
          wd_clr    = 1'b1;
          streak_d  = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        // an acknowledge in the expiry cycle still completes normally
        if (mbus.m_ack || wd_expired) begin
          state_d   = DONE;
          m_req_d   = 1'b0;
          bus_err_d = !mbus.m_ack;
          if (owner_q == OWNER_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = mbus.m_ack ? mbus.m_rdata : ERR_WORD;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mbus.m_ack ? mbus.m_rdata : ERR_WORD;
          end
        end
      end

      DONE: begin
        state_d    = IDLE;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_rdata_d = '0;
        d_rdata_d  = '0;
        bus_err_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign mbus.m_req   = m_req_q;
  assign mbus.m_we    = m_we_q;
  assign mbus.m_addr  = m_addr_q;
  assign mbus.m_wdata = m_wdata_q;
  assign mbus.m_be    = m_be_q;

  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign bus_err  = bus_err_q;

  assign if_stall = if_req & ~if_valid_q;
  assign d_stall  = d_req & ~d_valid_q;

endmodule
